sr_ff_bank: RTL and testbench
=============================

# sr_ff_bank

Parametrised bank of WIDTH independent set/reset flip-flop channels sharing one clock, one synchronous active-low reset, a global enable and a runtime-selectable mode (SR, JK, D, T). It is the multi-bit successor to the single-bit SR flip-flop. It adds a configurable policy for the S=R=1 collision, per-channel sticky collision flags and an optional saturating collision counter. It is used wherever control logic needs a register of latched set/clear bits with complementary outputs.

## Interface
- WIDTH, 8, number of channels (1..64)
- RESET_VAL, all zeros, WIDTH-bit value loaded into q on reset
- COLLIDE, 0, S=R=1 policy in SR mode: 0 hold, 1 set-dominant, 2 reset-dominant, 3 toggle
- CNT_W, 8, width of err_cnt (used only when the counter is compiled in)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk
- en  in  1  global update enable
- mode  in  2  00 SR, 01 JK, 10 D (s is data, r ignored), 11 T (s is toggle, r ignored)
- s  in  WIDTH  per-channel set / J / D / T
- r  in  WIDTH  per-channel reset / K
- err_clr  in  1  clears err (and err_cnt when present)
- q  out  WIDTH  channel state
- q_bar  out  WIDTH  always exactly ~q
- err  out  WIDTH  sticky per-channel SR collision flag
- err_cnt  out  CNT_W  saturating collision-cycle count (only with SR_FF_BANK_ERRCNT_EN)

## Operation
- Reset (rst_n=0 at a clk edge): q=RESET_VAL, q_bar=~RESET_VAL, err=0, err_cnt=0. Reset overrides en, err_clr and all data inputs. Asserting it mid-operation discards pending state.
- en=0: q, err and err_cnt hold. No collision detection takes place.
- en=1, per channel i:
  - SR: s=0,r=0 hold; s=1,r=0 set; s=0,r=1 clear; s=1,r=1 is a collision, and q follows COLLIDE.
  - JK: 00 hold, 10 set, 01 clear, 11 toggle. This is not a collision.
  - D: q=s.
  - T: q toggles when s=1.
- Collision (SR mode, en=1, s[i]&r[i]) sets err[i]. err[i] clears only on err_clr or reset.
- err_clr and a new collision on the same edge: err[i] ends at 1. The new event wins over the clear.
- err_cnt increments by exactly 1 per enabled cycle in which one or more channels collide, whatever the number of colliding channels. It saturates at all ones.
- err_clr and a counted cycle on the same edge: err_cnt=1.
- A mode change takes effect on the same edge at which it is sampled. No state is lost.

## Timing
- All state updates on the rising edge of clk. Latency from inputs to q is 1 cycle.
- q_bar is the complement of the registered q. It never differs from ~q in any cycle, including the reset cycle.
- err and err_cnt update on the same edge as the q change caused by the collision.
- No combinational path from inputs to outputs.

## Configuration
- SR_FF_BANK_ERRCNT_EN defined: the err_cnt port and the saturating counter are present.
- SR_FF_BANK_ERRCNT_EN undefined: the err_cnt port is removed and no counter logic is generated. All other behaviour, including err, is identical.

## Structure
- Package sr_ff_pkg holds:
  - the mode encoding constants (SR, JK, D, T)
  - the COLLIDE policy constants (HOLD, SET_DOM, RST_DOM, TOGGLE)
- Sub-module sr_ff_cell implements one channel. Its ports are clk, rst_n, en, mode, s, r, q and collision. It is instantiated WIDTH times by a generate loop.
- The top level holds the err register, the err_cnt counter, q_bar generation and collision reduction.

## Test plan
All scenarios use WIDTH=4 and RESET_VAL=4'b0101.
- Reset: rst_n=0 for 2 edges with s=4'hF, en=1 -> q=4'b0101, q_bar=4'b1010, err=0, err_cnt=0.
- SR mode, COLLIDE=0: from q=0, s=4'b0011, r=4'b0110 -> next edge q=4'b0001 (bit1 holds at 0), err=4'b0010, err_cnt=1.
- SR mode, COLLIDE=1 and =2: from q=0, s=r=4'hF -> q=4'hF and q=4'h0 respectively, err=4'hF, err_cnt=1.
- JK then T mode: from q=4'b1010, JK with s=r=4'hF -> q=4'b0101, err unchanged. Then T with s=4'b0001 -> q=4'b0100.
- en=0: s=4'hF, r=0 for 3 edges -> q, err and err_cnt unchanged.
- Counter saturation with CNT_W=2: 5 collision cycles -> err_cnt=3. err_clr plus a collision on the same edge -> err_cnt=1 and err stays set. err_clr alone -> err=0, err_cnt=0.

Source files
------------

// File: rtl/sr_ff_pkg.sv
// sr_ff_pkg: shared encodings for the sr_ff_bank slice.
//   - mode encoding for the per-channel update function (SR, JK, D, T)
//   - collision policy constants applied when S=R=1 in SR mode
package sr_ff_pkg;

  localparam logic [1:0] MODE_SR = 2'b00;
  localparam logic [1:0] MODE_JK = 2'b01;
  localparam logic [1:0] MODE_D  = 2'b10;
  localparam logic [1:0] MODE_T  = 2'b11;

  localparam int unsigned COL_HOLD    = 0;
  localparam int unsigned COL_SET_DOM = 1;
  localparam int unsigned COL_RST_DOM = 2;
  localparam int unsigned COL_TOGGLE  = 3;

endpackage

// File: rtl/sr_ff_cell.sv
// sr_ff_cell: one flip-flop channel of sr_ff_bank.
// Ports:
//   clk       in  rising-edge clock
//   rst_n     in  synchronous active-low reset (loads RESET_VAL)
//   en        in  update enable
//   mode      in  SR / JK / D / T select
//   s, r      in  set/J/D/T and reset/K inputs
//   q         out registered channel state
//   collision out combinational flag: enabled SR-mode cycle with s=r=1
module sr_ff_cell
  import sr_ff_pkg::*;
#(
  parameter int unsigned COLLIDE   = COL_HOLD,
  parameter logic        RESET_VAL = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] mode,
  input  logic       s,
  input  logic       r,
  output logic       q,
  output logic       collision
);

  logic r_q;
  logic w_nxt;
  logic w_col;

  always_comb begin
    w_nxt = r_q;
    w_col = 1'b0;
    if (en) begin
      case (mode)
        MODE_SR: begin
          case ({s, r})
            2'b10: w_nxt = 1'b1;
            2'b01: w_nxt = 1'b0;
            2'b11: begin
              w_col = 1'b1;
              case (COLLIDE)
                COL_SET_DOM: w_nxt = 1'b1;
                COL_RST_DOM: w_nxt = 1'b0;
                COL_TOGGLE:  w_nxt = ~r_q;
                default:     w_nxt = r_q;
              endcase
            end
            default: w_nxt = r_q;
          endcase
        end
        MODE_JK: begin
          case ({s, r})
            2'b10:   w_nxt = 1'b1;
            2'b01:   w_nxt = 1'b0;
            2'b11:   w_nxt = ~r_q;
            default: w_nxt = r_q;
          endcase
        end
        MODE_D:  w_nxt = s;
        default: w_nxt = r_q ^ s;  // T
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_q <= RESET_VAL;
    else        r_q <= w_nxt;
  end

  assign q         = r_q;
  assign collision = w_col;

endmodule

// File: rtl/sr_ff_bank.sv
// sr_ff_bank: WIDTH independent SR/JK/D/T flip-flop channels with
// complementary outputs, sticky per-channel SR collision flags and an
// optional saturating collision-cycle counter.
// Build option: SR_FF_BANK_ERRCNT_EN adds the err_cnt port and counter.
// Ports:
//   clk      in  rising-edge clock
//   rst_n    in  synchronous active-low reset
//   en       in  global update enable
//   mode     in  00 SR, 01 JK, 10 D, 11 T
//   s, r     in  per-channel data inputs
//   err_clr  in  clears err (and err_cnt)
//   q        out channel state
//   q_bar    out ~q
//   err      out sticky per-channel collision flags
//   err_cnt  out saturating count of colliding cycles (option only)
module sr_ff_bank
  import sr_ff_pkg::*;
#(
  parameter int unsigned           WIDTH     = 8,
  parameter logic [WIDTH-1:0]      RESET_VAL = '0,
  parameter int unsigned           COLLIDE   = COL_HOLD,
  parameter int unsigned           CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  input  logic             err_clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar,
  output logic [WIDTH-1:0] err
`ifdef SR_FF_BANK_ERRCNT_EN
  ,
  output logic [CNT_W-1:0] err_cnt
`endif
);

  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_col;
  logic [WIDTH-1:0] r_err;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    sr_ff_cell #(
      .COLLIDE   (COLLIDE),
      .RESET_VAL (RESET_VAL[i])
    ) u_cell (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .mode      (mode),
      .s         (s[i]),
      .r         (r[i]),
      .q         (w_q[i]),
      .collision (w_col[i])
    );
  end

  // A collision on the same edge as err_clr must survive the clear.
  always_ff @(posedge clk) begin
    if (!rst_n) r_err <= '0;
    else        r_err <= (err_clr ? '0 : r_err) | w_col;
  end

`ifdef SR_FF_BANK_ERRCNT_EN
  logic             w_any_col;
  logic [CNT_W-1:0] r_cnt;

  assign w_any_col = |w_col;

  // One count per colliding cycle regardless of how many channels collide.
  always_ff @(posedge clk) begin
    if (!rst_n)
      r_cnt <= '0;
    else if (err_clr)
      r_cnt <= w_any_col ? CNT_W'(1) : '0;
    else if (w_any_col && (r_cnt != '1))
      r_cnt <= r_cnt + CNT_W'(1);
  end

  assign err_cnt = r_cnt;
`endif

  assign q     = w_q;
  assign q_bar = ~w_q;
  assign err   = r_err;

endmodule

// File: tb/tb_sr_ff_bank.sv
// tb_sr_ff_bank: four banks (COLLIDE 0..3, the last with a 2-bit counter)
// driven by one shared directed stimulus stream; expected values are queued
// per edge and checked by an independent monitor.
module tb_sr_ff_bank;
  import sr_ff_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, en, err_clr;
  logic [1:0] mode;
  logic [3:0] s, r;

  logic [3:0] q_o  [4];
  logic [3:0] qb_o [4];
  logic [3:0] err_o[4];
  logic [7:0] cnt_o[4];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int unsigned CW = (g == 3) ? 2 : 8;
    logic [3:0]    qq, qb, ee;
    logic [CW-1:0] cc;
    sr_ff_bank #(
      .WIDTH(4), .RESET_VAL(4'b0101), .COLLIDE(g), .CNT_W(CW)
    ) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .s(s), .r(r),
      .err_clr(err_clr), .q(qq), .q_bar(qb), .err(ee)
`ifdef SR_FF_BANK_ERRCNT_EN
      , .err_cnt(cc)
`endif
    );
`ifndef SR_FF_BANK_ERRCNT_EN
    assign cc = '0;
`endif
    assign q_o[g]   = qq;
    assign qb_o[g]  = qb;
    assign err_o[g] = ee;
    assign cnt_o[g] = 8'(cc);
  end

  typedef struct {
    string      nm;
    int         d;
    logic [3:0] q;
    logic [3:0] e;
    int         c;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic push(input string nm, input logic [3:0] q0, q1, q2, q3,
                      input logic [3:0] e, input int c8, input int c2);
    logic [3:0] qs[4];
    qs[0] = q0; qs[1] = q1; qs[2] = q2; qs[3] = q3;
    for (int i = 0; i < 4; i++) begin
      exp_t x;
      x.nm = nm; x.d = i; x.q = qs[i]; x.e = e; x.c = (i == 3) ? c2 : c8;
      sbq.push_back(x);
    end
  endtask

  task automatic step(input logic rn, input logic e, input logic [1:0] m,
                      input logic [3:0] ss, input logic [3:0] rr,
                      input logic clr);
    @(negedge clk);
    rst_n = rn; en = e; mode = m; s = ss; r = rr; err_clr = clr;
    @(posedge clk);
  endtask

  // Monitor: checks everything queued for the edge just passed.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      while (sbq.size() > 0) begin
        exp_t x;
        x = sbq.pop_front();
        n_cmp++;
        if (q_o[x.d] !== x.q) begin
          n_err++;
          $display("FAIL %s dut%0d q: got %b want %b", x.nm, x.d, q_o[x.d], x.q);
        end
        n_cmp++;
        if (qb_o[x.d] !== ~x.q) begin
          n_err++;
          $display("FAIL %s dut%0d q_bar: got %b want %b", x.nm, x.d, qb_o[x.d], ~x.q);
        end
        n_cmp++;
        if (err_o[x.d] !== x.e) begin
          n_err++;
          $display("FAIL %s dut%0d err: got %b want %b", x.nm, x.d, err_o[x.d], x.e);
        end
`ifdef SR_FF_BANK_ERRCNT_EN
        n_cmp++;
        if (cnt_o[x.d] !== 8'(x.c)) begin
          n_err++;
          $display("FAIL %s dut%0d err_cnt: got %0d want %0d", x.nm, x.d, cnt_o[x.d], x.c);
        end
`endif
      end
    end
  end

  initial begin
    rst_n = 1'b0; en = 1'b1; mode = MODE_SR; s = 4'hF; r = 4'h0; err_clr = 1'b0;

    step(0, 1, MODE_SR, 4'hF, 4'h0, 0);
    push("reset1", 4'b0101, 4'b0101, 4'b0101, 4'b0101, 4'h0, 0, 0);
    step(0, 1, MODE_SR, 4'hF, 4'h0, 0);
    push("reset2", 4'b0101, 4'b0101, 4'b0101, 4'b0101, 4'h0, 0, 0);

    step(1, 1, MODE_D, 4'h0, 4'h0, 0);
    push("d_zero", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0);

    step(1, 1, MODE_SR, 4'b0011, 4'b0110, 0);
    push("sr_mix", 4'b0001, 4'b0011, 4'b0001, 4'b0011, 4'b0010, 1, 1);

    step(1, 1, MODE_D, 4'h0, 4'h0, 0);
    push("d_zero2", 4'h0, 4'h0, 4'h0, 4'h0, 4'b0010, 1, 1);

    step(1, 1, MODE_SR, 4'hF, 4'hF, 0);
    push("sr_all", 4'h0, 4'hF, 4'h0, 4'hF, 4'hF, 2, 2);

    step(1, 1, MODE_D, 4'b1010, 4'h0, 0);
    push("d_1010", 4'b1010, 4'b1010, 4'b1010, 4'b1010, 4'hF, 2, 2);

    step(1, 1, MODE_JK, 4'hF, 4'hF, 0);
    push("jk_tog", 4'b0101, 4'b0101, 4'b0101, 4'b0101, 4'hF, 2, 2);

    step(1, 1, MODE_T, 4'b0001, 4'h0, 0);
    push("t_bit0", 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'hF, 2, 2);

    step(1, 0, MODE_SR, 4'hF, 4'h0, 0);
    push("en0_a", 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'hF, 2, 2);
    step(1, 0, MODE_SR, 4'hF, 4'h0, 0);
    push("en0_b", 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'hF, 2, 2);
    step(1, 0, MODE_SR, 4'hF, 4'hF, 0);
    push("en0_col", 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'hF, 2, 2);

    step(1, 1, MODE_D, 4'b0100, 4'h0, 1);
    push("clr1", 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'h0, 0, 0);

    for (int k = 1; k <= 5; k++) begin
      step(1, 1, MODE_SR, 4'b0001, 4'b0001, 0);
      push("sat", 4'b0100, 4'b0101, 4'b0100, (k % 2 == 1) ? 4'b0101 : 4'b0100,
           4'b0001, k, (k > 3) ? 3 : k);
    end

    step(1, 1, MODE_SR, 4'b0001, 4'b0001, 1);
    push("clr_col", 4'b0100, 4'b0101, 4'b0100, 4'b0100, 4'b0001, 1, 1);

    step(1, 1, MODE_SR, 4'h0, 4'h0, 1);
    push("clr2", 4'b0100, 4'b0101, 4'b0100, 4'b0100, 4'h0, 0, 0);

    step(1, 1, MODE_SR, 4'b0010, 4'b0010, 0);
    push("sr_b1", 4'b0100, 4'b0111, 4'b0100, 4'b0110, 4'b0010, 1, 1);

    step(0, 1, MODE_SR, 4'hF, 4'hF, 0);
    push("reset_mid", 4'b0101, 4'b0101, 4'b0101, 4'b0101, 4'h0, 0, 0);

    repeat (3) @(posedge clk);
    #3;
    if (sbq.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: %0d entries left, want 0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule
